decode_regread: RTL
===================

// Module: decode_regread
// PURPOSE
//  RV32I decode + register-read stage; sits directly upstream of the ALU.
//  Accepts fetched instr/pc, splits fields, generates sign-extended immediate,
//  reads rs1/rs2 from the integer register file, registers result for the ALU.
//  Owns the register file; the writeback port writes results back into it.
// PARAMETERS
//  XLEN       32  datapath / register width
//  REG_COUNT  32  architectural registers; x0 hardwired to zero
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     fetch presents in_instr/in_pc
//  in_ready     out  1     stage can accept this cycle
//  in_instr     in   32    raw instruction word
//  in_pc        in   XLEN  pc of in_instr, passed through unchanged
//  flush        in   1     discard held + incoming instr (taken branch/jump)
//  wb_en        in   1     writeback strobe
//  wb_rd        in   5     writeback destination index
//  wb_data      in   XLEN  writeback value
//  out_valid    out  1     decoded bundle valid toward ALU
//  out_ready    in   1     ALU consumes bundle this cycle
//  out_opcode   out  7     instr[6:0]
//  out_funct3   out  3     instr[14:12]
//  out_funct7   out  7     instr[31:25]
//  out_rd       out  5     instr[11:7]; forced 0 for S/B types
//  out_rs1_val  out  XLEN  regfile[instr[19:15]]
//  out_rs2_val  out  XLEN  regfile[instr[24:20]]
//  out_imm      out  XLEN  sign-extended immediate
//  out_pc       out  XLEN  registered in_pc
//  out_illegal  out  1     opcode not in RV32I base set
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* = 0, all registers cleared to 0 in 1 cycle.
//  - in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//  - Latency 1: accepted instr appears on out_* next cycle with out_valid=1.
//  - Stall: out_valid & !out_ready -> every out_* held bit-stable, no accept.
//  - Consume without new accept -> out_valid=0 next cycle, out_* keep value.
//  - flush: next cycle out_valid=0; instr offered same cycle is dropped
//    (in_ready still asserted, acceptance ignored). flush beats accept.
//  - Immediate per opcode: I (0010011,0000011,1100111) {{20{i[31]}},i[31:20]};
//    S (0100011) {{20{i[31]}},i[31:25],i[11:7]};
//    B (1100011) {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0};
//    U (0110111,0010111) {i[31:12],12'b0};
//    J (1101111) {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}; else 0.
//  - Shift-imm (funct3 001/101, opcode 0010011): imm = {27'b0,i[24:20]}.
//  - Illegal opcode: out_illegal=1, out_imm=0, out_rd=0, still handshaken.
//  - Regfile write on wb_en & wb_rd!=0; writes to x0 ignored; x0 reads 0.
//  - Writeback and accept/stall are independent; wb never stalls.
//  - Operands sampled at accept; later wb does not alter a held bundle.
// CONFIGURATION
//  RF_BYPASS_EN defined: wb_data forwarded to rs1/rs2 read when wb_en and
//    wb_rd matches a nonzero source index in the accept cycle (write-first).
//  Not defined: same-cycle read returns old register value (read-first);
//    hazard avoidance is the scheduler's job.
// STRUCTURE
//  riscv_pkg: opcode localparams (OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH,
//    LOAD, STORE), imm_fmt_t enum {I,S,B,U,J,NONE}, XLEN default.
//  Sub-module reg_file: 2 async read ports, 1 sync write port, sync clear.
//  Top: imm generator (combinational function) + output pipeline register.
// TESTING
//  1 wb x5=0x0000_0011; accept addi x6,x5,-1 (0xFFF28313) -> next cycle
//    out_rs1_val=0x11, out_imm=0xFFFF_FFFF, out_rd=6, out_valid=1.
//  2 beq instr 0xFE000EE3 -> out_imm=0xFFFF_FFFC, out_rd=0, out_illegal=0.
//  3 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable,
//    then out_ready=1 -> next instr appears following cycle, none lost.
//  4 wb x7=0xDEAD_BEEF same cycle as accepting add x8,x7,x0 -> out_rs1_val=
//    0xDEADBEEF with RF_BYPASS_EN, 0x0 (prior value) without.
//  5 wb_en=1, wb_rd=0, wb_data=0x1234 then read x0 -> out_rs1_val=0.
//  6 flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0;
//    rst mid-stall -> out_valid=0 and x1..x31 read 0 afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, immediate format enum and decode helpers
// shared by the decode/register-read stage.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5
  } imm_fmt_t;

  // Opcodes belonging to the RV32I base set (FENCE and ECALL/EBREAK included).
  function automatic logic opcode_legal(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      OP_IMM, OP, LUI, AUIPC, JAL, JALR,
      BRANCH, LOAD, STORE, MISC_MEM, SYSTEM: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Immediate layout selected by opcode; FENCE/SYSTEM carry no immediate here.
  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // Sign-extended immediate; shift-immediates carry an unsigned shamt only.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I: begin
        if ((instr[6:0] == OP_IMM) &&
            ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101))) begin
          imm = {27'd0, instr[24:20]};
        end else begin
          imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'd0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: integer register file, two asynchronous read ports, one
// synchronous write port, synchronous clear. x0 always reads zero.
// Build option RF_BYPASS_EN: a same-cycle write to a read index is forwarded
// to that read port (write-first); without it reads return the old value.
module reg_file #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int AW        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic            w_we_eff;

  // Writes aimed at x0 are dropped so it stays zero.
  assign w_we_eff = we & (waddr != '0);

  // Storage: clear everything on reset, otherwise take the writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we_eff) begin
      r_regs[waddr] <= wdata;
    end else begin
      r_regs[waddr] <= r_regs[waddr];
    end
  end

  // Read port 1: x0 forced to zero, optional write-first forwarding.
  always_comb begin
    if (raddr1 == '0) begin
      rdata1 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (w_we_eff && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
`endif
    else begin
      rdata1 = r_regs[raddr1];
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    if (raddr2 == '0) begin
      rdata2 = '0;
    end
`ifdef RF_BYPASS_EN
    else if (w_we_eff && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
`endif
    else begin
      rdata2 = r_regs[raddr2];
    end
  end

endmodule

// File: rtl/decode_regread.sv
// decode_regread: RV32I decode + register-read stage feeding the ALU.
// Splits instruction fields, builds the immediate, reads rs1/rs2 and holds
// the bundle in a one-deep valid/ready output register. Owns the register
// file, written through the writeback port.
// Build option RF_BYPASS_EN: forward same-cycle writeback to operand reads.
module decode_regread
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic            w_accept;
  logic            w_legal;
  imm_fmt_t        w_fmt;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  logic            r_valid;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic            r_illegal;

  // Free slot whenever nothing is held or the ALU drains the held bundle.
  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  reg_file #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .AW        (5)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (in_instr[19:15]),
    .raddr2 (in_instr[24:20]),
    .rdata1 (w_rs1_val),
    .rdata2 (w_rs2_val)
  );

  // Decode the incoming word: legality, immediate and destination index.
  always_comb begin
    w_legal = opcode_legal(in_instr[6:0]);
    w_fmt   = imm_fmt(in_instr[6:0]);
    if (!w_legal) begin
      w_imm = '0;
      w_rd  = 5'd0;
    end else begin
      w_imm = XLEN'($signed(imm_gen(in_instr, w_fmt)));
      if ((w_fmt == FMT_S) || (w_fmt == FMT_B)) begin
        w_rd = 5'd0;
      end else begin
        w_rd = in_instr[11:7];
      end
    end
  end

  // Output register: flush wins over accept; a drain without accept only
  // drops valid so the bundle fields stay as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_funct7  <= 7'd0;
      r_rd      <= 5'd0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_opcode  <= in_instr[6:0];
      r_funct3  <= in_instr[14:12];
      r_funct7  <= in_instr[31:25];
      r_rd      <= w_rd;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_imm     <= w_imm;
      r_pc      <= in_pc;
      r_illegal <= ~w_legal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid   = r_valid;
  assign out_opcode  = r_opcode;
  assign out_funct3  = r_funct3;
  assign out_funct7  = r_funct7;
  assign out_rd      = r_rd;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_imm     = r_imm;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;

endmodule
